// File: rtl/rf_write_arbiter_pkg.sv
// rtl/rf_write_arbiter_pkg.sv - shared register-file widths and write-source encoding
package rf_write_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Which requester owns the write port in a given cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_LU   = 2'd2
  } wr_src_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - small FIFO buffering long-latency results awaiting the write port
module rf_wb_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ADDR_W-1:0]        push_rd,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [ADDR_W-1:0]        head_rd,
  output logic [DATA_W-1:0]        head_data,
  output logic                     full,
  output logic                     empty,
  output logic [DEPTH-1:0]         ent_vld,
  output logic [DEPTH*ADDR_W-1:0]  ent_rd
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [DEPTH-1:0]  vld;
  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign ent_vld   = vld;

  // Pointers, occupancy and per-entry valid bits; depth is a power of two so pointers wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (do_pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (do_push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Payload storage needs no reset; vld qualifies every slot
  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_mem[wr_ptr]   <= push_rd;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Flatten per-entry destinations for the pending-mask decoder
  always_comb begin
    ent_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd[i*ADDR_W +: ADDR_W] = rd_mem[i];
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - shares the register-file write port between WB and the long-latency unit
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W       = XLEN,
  parameter int ADDR_W       = REG_ADDR_W,
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  input  logic [ADDR_W-1:0]     wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [ADDR_W-1:0]     lu_rd,
  input  logic [DATA_W-1:0]     lu_data,
  output logic                  rf_we,
  output logic [ADDR_W-1:0]     rf_rd_addr,
  output logic [DATA_W-1:0]     rf_rd_data,
  output logic [2**ADDR_W-1:0]  pend_mask,
  output logic                  stall_req,
  output logic                  proto_err
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [ADDR_W-1:0]           head_rd;
  logic [DATA_W-1:0]           head_data;
  logic                        full;
  logic                        empty;
  logic [BUF_DEPTH-1:0]        ent_vld;
  logic [BUF_DEPTH*ADDR_W-1:0] ent_rd;
  logic                        push;
  logic                        pop;
  logic                        violation;
  wr_src_e                     src;
  logic [CNT_W-1:0]            starve_cnt;
  logic [CNT_W-1:0]            starve_cnt_next;

  // Acceptance looks only at registered occupancy, so a full buffer refuses even while popping
  assign lu_ready  = !rst && !full;
  assign push      = lu_valid && lu_ready && (lu_rd != '0);
  assign pop       = (src == SRC_LU);
  assign violation = wb_valid && stall_req;

  rf_wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (lu_rd),
    .push_data (lu_data),
    .pop       (pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .ent_vld   (ent_vld),
    .ent_rd    (ent_rd)
  );

  // Write-port mux: WB always wins, buffered head fills idle cycles; rd==0 never writes
  always_comb begin
    src        = SRC_NONE;
    rf_rd_addr = '0;
    rf_rd_data = '0;
    if (wb_valid) begin
      src = SRC_WB;
    end else if (!empty) begin
      src = SRC_LU;
    end
    case (src)
      SRC_WB: begin
        rf_rd_addr = wb_rd;
        rf_rd_data = wb_data;
      end
      SRC_LU: begin
        rf_rd_addr = head_rd;
        rf_rd_data = head_data;
      end
      default: ;
    endcase
    rf_we = !rst && (src != SRC_NONE) && (rf_rd_addr != '0);
  end

  // Pending destinations of every buffered entry; x0 is never reported
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (ent_vld[i]) begin
        pend_mask[ent_rd[i*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

  // Counts consecutive cycles the buffered head loses to WB
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (violation || empty || pop) begin
      starve_cnt_next = '0;
    end else if (wb_valid && (starve_cnt != CNT_MAX)) begin
      starve_cnt_next = starve_cnt + 1'b1;
    end
  end

  // Starvation state, one-shot stall request and sticky contract-violation flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_next;
      stall_req  <= (starve_cnt_next == CNT_MAX) && !stall_req;
      proto_err  <= proto_err || violation;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - randomized self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk;
  logic          rst;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          lu_valid;
  logic          lu_ready;
  logic [AW-1:0] lu_rd;
  logic [DW-1:0] lu_data;
  logic          rf_we;
  logic [AW-1:0] rf_rd_addr;
  logic [DW-1:0] rf_rd_data;
  logic [31:0]   pend_mask;
  logic          stall_req;
  logic          proto_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of {rd, data}, starvation count, stall and error flags
  logic [AW+DW-1:0] mq[$];
  int               m_cnt;
  bit               m_stall;
  bit               m_perr;

  rf_write_arbiter #(
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .BUF_DEPTH    (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_rd      (lu_rd),
    .lu_data    (lu_data),
    .rf_we      (rf_we),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .pend_mask  (pend_mask),
    .stall_req  (stall_req),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_cnt   = 0;
    m_stall = 0;
    m_perr  = 0;
  endtask

  // One cycle: drive at negedge, compare against the model, then advance the model at posedge
  task automatic step(input logic wv, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                      input logic lv, input logic [AW-1:0] lr, input logic [DW-1:0] ld);
    logic          exp_we;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    logic [31:0]   exp_pm;
    logic          exp_rdy;
    bit            was_empty;
    bit            popped;
    @(negedge clk);
    wb_valid = wv; wb_rd = wr; wb_data = wd;
    lu_valid = lv; lu_rd = lr; lu_data = ld;
    #1;
    exp_rdy = (mq.size() < DEPTH);
    exp_pm  = '0;
    foreach (mq[i]) exp_pm[mq[i][AW+DW-1:DW]] = 1'b1;
    exp_pm[0] = 1'b0;
    exp_a  = '0;
    exp_d  = '0;
    exp_we = 1'b0;
    if (wv) begin
      exp_we = (wr != 0); exp_a = wr; exp_d = wd;
    end else if (mq.size() > 0) begin
      exp_we = 1'b1; exp_a = mq[0][AW+DW-1:DW]; exp_d = mq[0][DW-1:0];
    end
    chk("rf_we", 64'(rf_we), 64'(exp_we));
    if (exp_we) begin
      chk("rf_rd_addr", 64'(rf_rd_addr), 64'(exp_a));
      chk("rf_rd_data", 64'(rf_rd_data), 64'(exp_d));
    end
    chk("lu_ready", 64'(lu_ready), 64'(exp_rdy));
    chk("pend_mask", 64'(pend_mask), 64'(exp_pm));
    chk("stall_req", 64'(stall_req), 64'(m_stall));
    chk("proto_err", 64'(proto_err), 64'(m_perr));
    @(posedge clk);
    was_empty = (mq.size() == 0);
    popped    = !wv && !was_empty;
    if (wv && m_stall) begin
      m_perr = 1; m_cnt = 0;
    end else if (was_empty || popped) begin
      m_cnt = 0;
    end else if (m_cnt < LIMIT) begin
      m_cnt++;
    end
    if (popped) void'(mq.pop_front());
    if (lv && exp_rdy && lr != 0) mq.push_back({lr, ld});
    m_stall = (m_cnt == LIMIT) && !m_stall;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Keep WB busy (offering rd 6 from the LU) until the model expects a stall request
  task automatic starve_until_stall();
    int k;
    k = 0;
    while (!m_stall && k < 20) begin
      step(1, 5'(1 + (k % 30)), $urandom, 1, 6, 32'h66);
      k++;
    end
    if (!m_stall) chk("stall_timeout", 0, 1);
  endtask

  initial begin
    logic wv;
    rst = 1'b1;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    model_clear();
    repeat (2) @(negedge clk);
    wb_valid = 1; wb_rd = 5;
    #1;
    chk("rst_rf_we", 64'(rf_we), 0);
    chk("rst_lu_ready", 64'(lu_ready), 0);
    chk("rst_pend", 64'(pend_mask), 0);
    chk("rst_stall", 64'(stall_req), 0);
    chk("rst_perr", 64'(proto_err), 0);
    wb_valid = 0; wb_rd = 0;
    @(negedge clk);
    rst = 1'b0;

    // WB only, including rd==0
    step(1, 5, 32'hDEADBEEF, 0, 0, 0);
    step(1, 0, 32'h12345678, 0, 0, 0);
    // LU only
    step(0, 0, 0, 1, 7, 32'h00001234);
    idle(2);
    // Discard rd==0, then duplicate rd 9
    step(0, 0, 0, 1, 0, 32'hAAAA);
    idle(1);
    step(1, 1, 32'h1, 1, 9, 32'h91);
    step(1, 2, 32'h2, 1, 9, 32'h92);
    idle(3);
    // Starvation with one entry buffered, then a clean stall cycle
    step(1, 3, 32'h3, 1, 11, 32'hB0B);
    starve_until_stall();
    idle(3);
    // Fill buffer, stall, violate, stall again, then reset asynchronously mid-operation
    step(1, 2, 32'h2, 1, 3, 32'h33);
    step(1, 2, 32'h2, 1, 4, 32'h44);
    starve_until_stall();
    step(1, 8, 32'h88, 1, 6, 32'h66);
    starve_until_stall();
    @(negedge clk);
    wb_valid = 0; lu_valid = 0;
    #1;
    chk("pre_rst_stall", 64'(stall_req), 1);
    chk("pre_rst_perr", 64'(proto_err), 1);
    chk("pre_rst_full", 64'(lu_ready), 0);
    #1 rst = 1'b1;
    #1;
    chk("async_rf_we", 64'(rf_we), 0);
    chk("async_pend", 64'(pend_mask), 0);
    chk("async_stall", 64'(stall_req), 0);
    chk("async_perr", 64'(proto_err), 0);
    chk("async_lu_ready", 64'(lu_ready), 0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_lu_ready", 64'(lu_ready), 1);

    // Full buffer with a held third offer, retiring in order 3, 4, 6
    step(1, 1, 32'h1, 1, 3, 32'h33);
    step(1, 1, 32'h1, 1, 4, 32'h44);
    step(1, 1, 32'h1, 1, 6, 32'h66);
    step(0, 0, 0, 1, 6, 32'h66);
    step(0, 0, 0, 1, 6, 32'h66);
    idle(3);

    // Randomized traffic, mostly honouring the stall contract
    for (int i = 0; i < 600; i++) begin
      if (m_stall) wv = ($urandom_range(0, 15) == 0);
      else         wv = ($urandom_range(0, 3) != 0);
      step(wv, 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 12)), $urandom);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
